// File: rtl/sig_burst_ctrl.sv
// Square-wave burst sequencer: toggles sig num_toggles times every half_period cycles.
// Optional build macro SIG_BURST_CONTINUOUS_EN: num_toggles=0 runs until abort.
module sig_burst_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned NUM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] half_period,
    input  logic [NUM_W-1:0] num_toggles,
    input  logic             abort,
    output logic             busy,
    output logic             sig,
    output logic             done,
    output logic [NUM_W-1:0] toggle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] cnt_d;
    logic             sig_d, done_d, busy_d;
    logic             go_run;

    // A request runs only when it has a nonzero half-period and a usable toggle count.
`ifdef SIG_BURST_CONTINUOUS_EN
    assign go_run = (half_period != '0);
`else
    assign go_run = (half_period != '0) && (num_toggles != '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            hp_q       <= '0;
            num_q      <= '0;
            toggle_cnt <= '0;
            sig        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hp_q       <= hp_d;
            num_q      <= num_d;
            toggle_cnt <= cnt_d;
            sig        <= sig_d;
            done       <= done_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hp_d    = hp_q;
        num_d   = num_q;
        cnt_d   = toggle_cnt;
        sig_d   = sig;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                sig_d = 1'b0;
                if (start) begin
                    hp_d  = half_period;
                    num_d = num_toggles;
                    cnt_d = '0;
                    if (go_run) begin
                        timer_d = half_period;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort wins over a simultaneous timer expiry: no toggle that cycle.
                if (abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (timer_q == CNT_W'(1)) begin
                    sig_d   = ~sig;
                    cnt_d   = toggle_cnt + NUM_W'(1);
                    timer_d = hp_q;
                    // A latched count of zero only reaches RUN as a continuous burst.
                    if ((num_q != '0) && (cnt_d == num_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            DONE: begin
                sig_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                sig_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_sig_burst_ctrl.sv
// Self-checking bench for sig_burst_ctrl: per-cycle expectations queued from burst timing formulas.
module tb_sig_burst_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NUM_W = 4;

    typedef struct packed {
        logic             busy;
        logic             sig;
        logic             done;
        logic [NUM_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] half_period;
    logic [NUM_W-1:0] num_toggles;
    logic             abort;
    logic             busy;
    logic             sig;
    logic             done;
    logic [NUM_W-1:0] toggle_cnt;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    sig_burst_ctrl #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .half_period (half_period),
        .num_toggles (num_toggles),
        .abort       (abort),
        .busy        (busy),
        .sig         (sig),
        .done        (done),
        .toggle_cnt  (toggle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input bit b, input bit s, input bit d, input int c);
        exp_t e;
        e.busy = b;
        e.sig  = s;
        e.done = d;
        e.cnt  = NUM_W'(c);
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.busy = busy;
        o.sig  = sig;
        o.done = done;
        o.cnt  = toggle_cnt;
        return o;
    endfunction

    // Entry j is the expected output just after edge E0+j; a = abort edge offset (0 = none).
    function automatic void gen_burst(input int hp, input int n, input int a, input bit cont);
        int t, end_j, kend, k;
        if (hp == 0 || (n == 0 && !cont)) begin
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 0));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
            return;
        end
        t = cont ? 32'h3fff_ffff : n * hp;
        if (a > 0 && a <= t) begin
            end_j = a;
            kend  = (a - 1) / hp;
        end else begin
            end_j = t;
            kend  = n;
        end
        for (int j = 0; j < end_j; j++) begin
            k = j / hp;
            exp_q.push_back(mk(1'b1, bit'(k % 2), 1'b0, k));
        end
        exp_q.push_back(mk(1'b1, bit'(kend % 2), 1'b1, kend));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, kend));
    endfunction

    task automatic test_reset();
        exp_t o;
        #2;
        o = observe();
        checks++;
        if (o !== mk(1'b0, 1'b0, 1'b0, 0)) begin
            errors++;
            $display("FAIL reset_values got %b want %b", o, mk(1'b0, 1'b0, 1'b0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            o = observe();
            checks++;
            if (o !== mk(1'b0, 1'b0, 1'b0, 0)) begin
                errors++;
                $display("FAIL idle_abort_ignored cyc=%0d got %b want %b", i, o, mk(1'b0, 1'b0, 1'b0, 0));
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e, o;
        int   j;
        gen_burst(10, 5, 0, 1'b0);
        start = 1'b1; half_period = 8'd10; num_toggles = 4'd5;
        j = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic j=%0d busy/sig/done/cnt got %b want %b", j, o, e);
            end
            j++;
        end
    endtask

    task automatic test_abort();
        exp_t e, o;
        int   j;
        int   ab[2] = '{7, 9};
        for (int c = 0; c < 2; c++) begin
            gen_burst(3, 4, ab[c], 1'b0);
            start = 1'b1; half_period = 8'd3; num_toggles = 4'd4;
            j = 0;
            while (exp_q.size() > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
                e = exp_q.pop_front();
                o = observe();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_at_%0d j=%0d got %b want %b", ab[c], j, o, e);
                end
                abort = (j + 1 == ab[c]);
                j++;
            end
            abort = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        int   j;
        gen_burst(4, 3, 0, 1'b0);
        start = 1'b1; half_period = 8'd4; num_toggles = 4'd3;
        j = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy_start_ignored j=%0d got %b want %b", j, o, e);
            end
            // Re-request with different fields while busy; must have no effect.
            start = (j + 1 >= 3) && (j + 1 <= 5);
            half_period = 8'd1; num_toggles = 4'd1;
            j++;
        end
        gen_burst(2, 1, 0, 1'b0);
        start = 1'b1; half_period = 8'd2; num_toggles = 4'd1;
        j = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL first_idle_start j=%0d got %b want %b", j, o, e);
            end
            j++;
        end
    endtask

    task automatic test_zero();
        exp_t e, o;
        int   hps[2] = '{0, 5};
        int   ns[2]  = '{3, 0};
        int   ncase;
`ifdef SIG_BURST_CONTINUOUS_EN
        ncase = 1;
`else
        ncase = 2;
`endif
        for (int c = 0; c < ncase; c++) begin
            gen_burst(hps[c], ns[c], 0, 1'b0);
            start = 1'b1; half_period = CNT_W'(hps[c]); num_toggles = NUM_W'(ns[c]);
            for (int j = 0; exp_q.size() > 0; j++) begin
                @(posedge clk); #1;
                start = 1'b0;
                e = exp_q.pop_front();
                o = observe();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL zero_field hp=%0d n=%0d j=%0d got %b want %b", hps[c], ns[c], j, o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        gen_burst(2, 8, 0, 1'b0);
        start = 1'b1; half_period = 8'd2; num_toggles = 4'd8;
        for (int j = 0; j <= 5; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pre_reset j=%0d got %b want %b", j, o, e);
            end
        end
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== mk(1'b0, 1'b0, 1'b0, 0)) begin
            errors++;
            $display("FAIL async_reset got %b want %b", o, mk(1'b0, 1'b0, 1'b0, 0));
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            o = observe();
            checks++;
            if (o !== mk(1'b0, 1'b0, 1'b0, 0)) begin
                errors++;
                $display("FAIL held_reset cyc=%0d got %b want %b", i, o, mk(1'b0, 1'b0, 1'b0, 0));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        gen_burst(1, 3, 0, 1'b0);
        start = 1'b1; half_period = 8'd1; num_toggles = 4'd3;
        for (int j = 0; exp_q.size() > 0; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset j=%0d got %b want %b", j, o, e);
            end
        end
    endtask

`ifdef SIG_BURST_CONTINUOUS_EN
    task automatic test_continuous();
        exp_t e, o;
        gen_burst(1, 0, 20, 1'b1);
        start = 1'b1; half_period = 8'd1; num_toggles = 4'd0;
        for (int j = 0; exp_q.size() > 0; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL continuous j=%0d got %b want %b", j, o, e);
            end
            abort = (j + 1 == 20);
        end
        abort = 1'b0;
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        half_period = '0;
        num_toggles = '0;
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_zero();
        test_reset_mid();
`ifdef SIG_BURST_CONTINUOUS_EN
        test_continuous();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sig_burst_ctrl.md
# sig_burst_ctrl

Synthesizable sequencer for the square-wave signal generator. It accepts a burst request (half-period, toggle count), drives `sig` with that many toggles at the programmed rate, and reports completion. It replaces free-running, delay-based toggling with a clocked FSM so that a host or testbench can schedule, abort and count bursts cycle-exactly.

## Interface
- `CNT_W`, default 8: width of the half-period field and the cycle timer.
- `NUM_W`, default 4: width of the toggle-count field and the toggle counter.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request pulse; sampled only in IDLE.
- `half_period`  in  CNT_W: cycles between toggles; latched on accepted `start`.
- `num_toggles`  in  NUM_W: toggles per burst; latched on accepted `start`.
- `abort`  in  1: terminates an active burst.
- `busy`  out  1: high in RUN and DONE.
- `sig`  out  1: generated waveform, registered.
- `done`  out  1: one-cycle completion pulse, registered.
- `toggle_cnt`  out  NUM_W: toggles issued in the current or last burst.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE (reset state): `sig`=0, `busy`=0.
  - `start`=1 with both fields nonzero: latch fields, load timer with `half_period`, clear `toggle_cnt`, go to RUN.
  - `start`=1 with either field zero: go to DONE without toggling. `SIG_BURST_CONTINUOUS_EN` changes this for `num_toggles`=0.
- RUN: the timer decrements each cycle. When the timer equals 1:
  - invert `sig`;
  - increment `toggle_cnt`;
  - reload the timer with the latched half-period.
  - If the new `toggle_cnt` equals the latched count, go to DONE.
- DONE: `done`=1 for exactly this one cycle. `sig` holds its final level. Next state is IDLE, where `sig` is cleared to 0.
- `abort` in RUN:
  - go to DONE next edge;
  - no toggle that cycle, even if the timer expires simultaneously (abort has priority);
  - `toggle_cnt` keeps its value.
- `abort` in IDLE or DONE: ignored.
- `start` while `busy`: ignored, with no queueing.
- Counter widths: the timer is CNT_W bits and `toggle_cnt` is NUM_W bits. No overflow is possible because the terminal count is at most 2^NUM_W−1.
- `toggle_cnt` holds after the burst until the next accepted `start`.

## Timing
- Reset values: `sig`=0, `busy`=0, `done`=0, `toggle_cnt`=0, state IDLE, timer 0. All are asserted asynchronously on `rst_n` falling. Reset mid-burst abandons the burst and produces no `done`.
- Let E0 be the edge that samples an accepted `start`:
  - `busy`=1 from E0.
  - Toggle k occurs at edge E0 + k·`half_period`, for k = 1..N.
  - State DONE at edge E0 + N·hp, with `done` high for the following cycle.
  - IDLE at E0 + N·hp + 1: `busy`=0, `sig`=0.
- Zero-field request: DONE at E0, `done` high for one cycle, IDLE at E0+1.
- Abort sampled at edge Ea: DONE at Ea, IDLE at Ea+1.
- Back-to-back bursts: the earliest next accepted `start` is the edge entering IDLE + 1, so there is at least one idle cycle between bursts.

## Configuration
- `SIG_BURST_CONTINUOUS_EN`
  - Defined: `num_toggles`=0 with `half_period`≠0 starts a continuous burst. It toggles every `half_period` cycles until `abort`. `toggle_cnt` wraps modulo 2^NUM_W and never triggers DONE on its own.
  - Undefined: `num_toggles`=0 is a zero-length request and completes immediately as described above.

## Test plan
- `half_period`=10, `num_toggles`=5, start at E0 -> `sig` toggles at E0+10, +20, +30, +40, +50 (ends at 1); `done` high during cycle after E0+50; `sig`=0 and `busy`=0 at E0+51; `toggle_cnt`=5.
- `half_period`=3, `num_toggles`=4; abort at E0+7 -> toggles only at +3 and +6; DONE at +7; `toggle_cnt`=2; `sig`=0 at +8. Also abort exactly at E0+9 (timer expiry) -> no third toggle.
- `start` re-asserted during a burst (hp=4, N=3) -> ignored; the burst completes at E0+12 with original values. A new `start` in the first IDLE cycle is accepted.
- `num_toggles`=0 or `half_period`=0 without the macro -> `done` at E0 cycle, no `sig` activity, `toggle_cnt`=0.
- `rst_n` low at E0+5 of an hp=2, N=8 burst -> all outputs immediately reset values; no `done`. After release, a new burst runs normally.
- With `SIG_BURST_CONTINUOUS_EN` defined: hp=1, N=0 -> `sig` toggles every cycle; `toggle_cnt` wraps 15->0 (NUM_W=4); abort -> single `done`, then `sig`=0.
